csr_ctrl: RTL and testbench

//  Machine-mode CSR file and trap/interrupt sequencer for the CPU; sits beside the EX-stage ALU.

---
 rtl/csr_pkg.sv | 37 +++
 rtl/csr_counter64.sv | 29 ++
 rtl/csr_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_csr_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR block: addresses, cause codes,
// bit positions and the trap sequencer state type.
package csr_pkg;

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

   localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
   localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;
   localparam int MIP_MEIP = 11;
   localparam int MIP_MTIP = 7;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      TRAP = 2'd1,
      RET  = 2'd2,
      WFI  = 2'd3
   } csr_state_t;

endpackage

// File: rtl/csr_counter64.sv
// Free-running counter with independently writable 32-bit halves.
// A write to either half suppresses that cycle's increment entirely.
module csr_counter64 #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         we_lo,
   input  logic         we_hi,
   input  logic [31:0]  wdata,
   output logic [W-1:0] q
);

   localparam int HW = W - 32;

   // count, or load the addressed half
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (we_lo || we_hi) begin
         if (we_lo) q[31:0] <= wdata;
         if (we_hi) q[W-1:32] <= HW'(wdata);
      end else if (inc) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/csr_ctrl.sv
// Machine-mode CSR file plus interrupt entry / MRET / WFI sequencer.
//
//  state | meaning
//  RUN   | normal execution, watching for interrupts, mret and wfi
//  TRAP  | interrupt taken; redirect fetch to mtvec for one cycle
//  RET   | mret executed; redirect fetch to mepc for one cycle
//  WFI   | pipeline asleep until any enabled interrupt is pending
module csr_ctrl
   import csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
   parameter int          CNT_W     = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] csr_raddr,
   output logic [31:0] csr_rdata,
   input  logic        csr_we,
   input  logic [11:0] csr_waddr,
   input  logic [31:0] csr_wdata,
   input  logic        inst_retire,
   input  logic [31:0] pc_resume,
   input  logic        mret,
   input  logic        wfi,
   input  logic        ext_irq,
   input  logic        tmr_irq,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        sleep
);

   csr_state_t state, state_nxt;

   logic              st_mie, st_mpie;
   logic              meie, mtie;
   logic [31:0]       mtvec, mepc, mcause;
   logic [CNT_W-1:0]  mcycle, minstret;

   logic [31:0]       mstatus_v, mie_v, mip_v, pend_v;
   logic              any_pend, take;
   logic              trap_upd, ret_upd;
   logic              we_mstatus, we_mie, we_mtvec, we_mepc, we_mcause;
   logic              mie_after_wr, mpie_after_wr;

   assign we_mstatus = csr_we && (csr_waddr == ADDR_MSTATUS);
   assign we_mie     = csr_we && (csr_waddr == ADDR_MIE);
   assign we_mtvec   = csr_we && (csr_waddr == ADDR_MTVEC);
   assign we_mepc    = csr_we && (csr_waddr == ADDR_MEPC);
   assign we_mcause  = csr_we && (csr_waddr == ADDR_MCAUSE);

   // architectural views of the packed status/enable/pending registers
   always_comb begin
      mstatus_v = '0;
      mstatus_v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mstatus_v[MSTATUS_MPIE] = st_mpie;
      mstatus_v[MSTATUS_MIE]  = st_mie;
      mie_v = '0;
      mie_v[MIP_MEIP] = meie;
      mie_v[MIP_MTIP] = mtie;
      mip_v = '0;
      mip_v[MIP_MEIP] = ext_irq;
      mip_v[MIP_MTIP] = tmr_irq;
   end

   assign pend_v   = mip_v & mie_v;
   assign any_pend = |pend_v;
   assign take     = st_mie && any_pend;

   // The CSR write lands first; trap/mret field updates are layered on top.
   assign mie_after_wr  = we_mstatus ? csr_wdata[MSTATUS_MIE]  : st_mie;
   assign mpie_after_wr = we_mstatus ? csr_wdata[MSTATUS_MPIE] : st_mpie;

   // old-value read mux for the ALU src2 path
   always_comb begin
      csr_rdata = '0;
      case (csr_raddr)
         ADDR_MSTATUS:                csr_rdata = mstatus_v;
         ADDR_MIE:                    csr_rdata = mie_v;
         ADDR_MIP:                    csr_rdata = mip_v;
         ADDR_MTVEC:                  csr_rdata = mtvec;
         ADDR_MEPC:                   csr_rdata = mepc;
         ADDR_MCAUSE:                 csr_rdata = mcause;
         ADDR_MCYCLE,   ADDR_CYCLE:   csr_rdata = mcycle[31:0];
         ADDR_MCYCLEH,  ADDR_CYCLEH:  csr_rdata = 32'(mcycle[CNT_W-1:32]);
         ADDR_MINSTRET, ADDR_INSTRET: csr_rdata = minstret[31:0];
         ADDR_MINSTRETH, ADDR_INSTRETH: csr_rdata = 32'(minstret[CNT_W-1:32]);
         default:                     csr_rdata = '0;
      endcase
   end

   // sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   // next state, trap/return strobes and fetch-side outputs
   always_comb begin
      state_nxt   = state;
      trap_upd    = 1'b0;
      ret_upd     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      sleep       = 1'b0;
      case (state)
         RUN: begin
            if (take) begin
               state_nxt = TRAP;
               trap_upd  = 1'b1;
            end else if (mret) begin
               state_nxt = RET;
               ret_upd   = 1'b1;
            end else if (wfi) begin
               state_nxt = WFI;
            end
         end
         TRAP: begin
            redirect    = 1'b1;
            redirect_pc = mtvec;
            state_nxt   = RUN;
         end
         RET: begin
            redirect    = 1'b1;
            redirect_pc = mepc;
            state_nxt   = RUN;
         end
         WFI: begin
            sleep = 1'b1;
            // wake on any enabled pending interrupt, trap only if globally enabled
            if (take) begin
               state_nxt = TRAP;
               trap_upd  = 1'b1;
            end else if (any_pend) begin
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // mstatus MIE/MPIE with trap entry and mret overriding the write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_mie  <= 1'b0;
         st_mpie <= 1'b0;
      end else if (trap_upd) begin
         st_mpie <= mie_after_wr;
         st_mie  <= 1'b0;
      end else if (ret_upd) begin
         st_mie  <= mpie_after_wr;
         st_mpie <= 1'b1;
      end else begin
         st_mie  <= mie_after_wr;
         st_mpie <= mpie_after_wr;
      end
   end

   // interrupt enables and trap vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meie  <= 1'b0;
         mtie  <= 1'b0;
         mtvec <= {MTVEC_RST[31:2], 2'b00};
      end else begin
         if (we_mie) begin
            meie <= csr_wdata[MIP_MEIP];
            mtie <= csr_wdata[MIP_MTIP];
         end
         if (we_mtvec) mtvec <= {csr_wdata[31:2], 2'b00};
      end
   end

   // exception PC and cause; trap entry overrides a same-cycle write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mepc   <= '0;
         mcause <= '0;
      end else if (trap_upd) begin
         mepc   <= pc_resume;
         mcause <= pend_v[MIP_MEIP] ? CAUSE_MEI : CAUSE_MTI;
      end else begin
         if (we_mepc)   mepc   <= {csr_wdata[31:2], 2'b00};
         if (we_mcause) mcause <= csr_wdata;
      end
   end

   csr_counter64 #(.W(CNT_W)) u_mcycle (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (1'b1),
      .we_lo (csr_we && (csr_waddr == ADDR_MCYCLE)),
      .we_hi (csr_we && (csr_waddr == ADDR_MCYCLEH)),
      .wdata (csr_wdata),
      .q     (mcycle)
   );

   csr_counter64 #(.W(CNT_W)) u_minstret (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inst_retire),
      .we_lo (csr_we && (csr_waddr == ADDR_MINSTRET)),
      .we_hi (csr_we && (csr_waddr == ADDR_MINSTRETH)),
      .wdata (csr_wdata),
      .q     (minstret)
   );

endmodule

// File: tb/tb_csr_ctrl.sv
// Scoreboard bench for csr_ctrl: stimulus pushes expectations, a negedge
// monitor pops and compares read data / sleep, and every redirect pulse.
module tb_csr_ctrl;

   localparam logic [31:0] MTVEC_INIT = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] csr_raddr = '0;
   logic [31:0] csr_rdata;
   logic        csr_we = 1'b0;
   logic [11:0] csr_waddr = '0;
   logic [31:0] csr_wdata = '0;
   logic        inst_retire = 1'b0;
   logic [31:0] pc_resume = '0;
   logic        mret = 1'b0;
   logic        wfi = 1'b0;
   logic        ext_irq = 1'b0;
   logic        tmr_irq = 1'b0;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        sleep;

   csr_ctrl #(.MTVEC_RST(MTVEC_INIT), .CNT_W(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .csr_raddr   (csr_raddr),
      .csr_rdata   (csr_rdata),
      .csr_we      (csr_we),
      .csr_waddr   (csr_waddr),
      .csr_wdata   (csr_wdata),
      .inst_retire (inst_retire),
      .pc_resume   (pc_resume),
      .mret        (mret),
      .wfi         (wfi),
      .ext_irq     (ext_irq),
      .tmr_irq     (tmr_irq),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .sleep       (sleep)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        is_sleep;
      logic [31:0] exp;
   } chk_t;

   chk_t        chk_q[$];
   logic [31:0] redir_q[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   // reference cycle count since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // monitor: redirects are matched as they appear, reads/sleep as queued
   always @(negedge clk) begin
      if (rst_n && redirect) begin
         checks++;
         if (redir_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_redirect: got pc=%h, none expected", redirect_pc);
         end else begin
            logic [31:0] e;
            e = redir_q.pop_front();
            if (redirect_pc !== e) begin
               errors++;
               $display("FAIL redirect_pc: got %h, expected %h", redirect_pc, e);
            end
         end
      end
      if (chk_q.size() > 0) begin
         chk_t c;
         logic [31:0] act;
         c = chk_q.pop_front();
         act = c.is_sleep ? {31'b0, sleep} : csr_rdata;
         checks++;
         if (act !== c.exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", c.name, act, c.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_we = 1'b1;
      csr_waddr = a;
      csr_wdata = d;
      tick();
      csr_we = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, input logic [31:0] e, input string n);
      chk_t c;
      csr_raddr = a;
      c.name = n;
      c.is_sleep = 1'b0;
      c.exp = e;
      chk_q.push_back(c);
      tick();
   endtask

   task automatic chk_sleep(input logic e, input string n);
      chk_t c;
      c.name = n;
      c.is_sleep = 1'b1;
      c.exp = {31'b0, e};
      chk_q.push_back(c);
      tick();
   endtask

   task automatic summary();
      $display("Result: errors=%0d of %0d checks", errors, checks);
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      summary();
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // reset values and cycle counting
      rd(12'hB00, cyc, "mcycle_after_reset");
      rd(12'h300, 32'h0000_1800, "mstatus_reset");
      rd(12'h305, MTVEC_INIT, "mtvec_reset");
      rd(12'h341, 32'h0, "mepc_reset");
      rd(12'h342, 32'h0, "mcause_reset");
      rd(12'h304, 32'h0, "mie_reset");
      chk_sleep(1'b0, "sleep_reset");
      rd(12'hB00, cyc, "mcycle_count_a");
      rd(12'hB00, cyc, "mcycle_count_b");
      rd(12'hC00, cyc, "cycle_mirror");

      // register write masking
      wr(12'h305, 32'h0000_0103);
      rd(12'h305, 32'h0000_0100, "mtvec_align");
      wr(12'h304, 32'hFFFF_FFFF);
      rd(12'h304, 32'h0000_0880, "mie_mask");
      wr(12'h300, 32'hFFFF_FFF7);
      rd(12'h300, 32'h0000_1880, "mstatus_mask");
      wr(12'h300, 32'h0);
      wr(12'h341, 32'h0001_2347);
      rd(12'h341, 32'h0001_2344, "mepc_align");
      wr(12'h342, 32'hDEAD_BEEF);
      rd(12'h342, 32'hDEAD_BEEF, "mcause_full");
      wr(12'h7C0, 32'h0000_0123);
      rd(12'h7C0, 32'h0, "unimpl_read");

      // mcycle carry, write beats increment, mirrors are read-only
      wr(12'hB00, 32'hFFFF_FFFF);
      rd(12'hB00, 32'hFFFF_FFFF, "mcycle_written");
      rd(12'hB00, 32'h0, "mcycle_wrap_lo");
      rd(12'hB80, 32'h1, "mcycle_carry_hi");
      wr(12'hC00, 32'h0);
      rd(12'hC00, 32'h3, "cycle_mirror_ro");
      rd(12'hC80, 32'h1, "cycleh_mirror");

      // minstret
      inst_retire = 1'b1;
      repeat (3) tick();
      inst_retire = 1'b0;
      rd(12'hB02, 32'h3, "minstret_count");
      wr(12'hB82, 32'h7);
      rd(12'hC82, 32'h7, "instreth_mirror");

      // external interrupt entry
      wr(12'h304, 32'h0000_0800);
      wr(12'h300, 32'h0000_0008);
      pc_resume = 32'h40;
      ext_irq = 1'b1;
      redir_q.push_back(32'h0000_0100);
      tick();
      ext_irq = 1'b0;
      rd(12'h341, 32'h40, "trap_mepc");
      rd(12'h342, 32'h8000_000B, "trap_mcause_ext");
      rd(12'h300, 32'h0000_1880, "trap_mstatus");

      // both pending: external wins; then mret
      wr(12'h304, 32'h0000_0880);
      wr(12'h300, 32'h0000_0008);
      pc_resume = 32'h80;
      ext_irq = 1'b1;
      tmr_irq = 1'b1;
      redir_q.push_back(32'h0000_0100);
      tick();
      ext_irq = 1'b0;
      tmr_irq = 1'b0;
      rd(12'h342, 32'h8000_000B, "prio_mcause");
      mret = 1'b1;
      redir_q.push_back(32'h80);
      tick();
      mret = 1'b0;
      rd(12'h300, 32'h0000_1888, "mret_mstatus");

      // wfi with MIE=0: wake without trapping
      wr(12'h300, 32'h0);
      wr(12'h304, 32'h0000_0080);
      wfi = 1'b1;
      tick();
      wfi = 1'b0;
      chk_sleep(1'b1, "wfi_sleep");
      tmr_irq = 1'b1;
      chk_sleep(1'b1, "wfi_sleep_hold");
      chk_sleep(1'b0, "wfi_wake_noirq");
      tmr_irq = 1'b0;
      rd(12'h342, 32'h8000_000B, "wfi_mcause_kept");

      // wfi with MIE=1: wake into trap
      wr(12'h300, 32'h0000_0008);
      wfi = 1'b1;
      tick();
      wfi = 1'b0;
      chk_sleep(1'b1, "wfi2_sleep");
      pc_resume = 32'hC0;
      tmr_irq = 1'b1;
      redir_q.push_back(32'h0000_0100);
      tick();
      tmr_irq = 1'b0;
      chk_sleep(1'b0, "wfi2_wake");
      rd(12'h342, 32'h8000_0007, "wfi2_mcause_tmr");
      rd(12'h341, 32'hC0, "wfi2_mepc");

      // mstatus write in the same cycle as take
      wr(12'h300, 32'h0000_0008);
      csr_we = 1'b1;
      csr_waddr = 12'h300;
      csr_wdata = 32'h0;
      tmr_irq = 1'b1;
      pc_resume = 32'h44;
      redir_q.push_back(32'h0000_0100);
      tick();
      csr_we = 1'b0;
      tmr_irq = 1'b0;
      rd(12'h300, 32'h0000_1800, "we_take_mstatus");
      rd(12'h341, 32'h44, "we_take_mepc");

      // take together with mret: trap wins, mret dropped
      wr(12'h300, 32'h0000_0008);
      mret = 1'b1;
      tmr_irq = 1'b1;
      pc_resume = 32'h48;
      redir_q.push_back(32'h0000_0100);
      tick();
      mret = 1'b0;
      tmr_irq = 1'b0;
      rd(12'h341, 32'h48, "take_mret_mepc");
      rd(12'h300, 32'h0000_1880, "take_mret_mstatus");

      // mip reflects the interrupt lines
      ext_irq = 1'b1;
      tmr_irq = 1'b1;
      rd(12'h344, 32'h0000_0880, "mip_both");
      ext_irq = 1'b0;
      tmr_irq = 1'b0;
      rd(12'h344, 32'h0, "mip_none");

      // reset while sleeping
      wfi = 1'b1;
      tick();
      wfi = 1'b0;
      chk_sleep(1'b1, "wfi3_sleep");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_sleep(1'b0, "reset_wfi_sleep");
      rd(12'h300, 32'h0000_1800, "reset_wfi_mstatus");
      rd(12'h305, MTVEC_INIT, "reset_wfi_mtvec");

      repeat (3) tick();
      checks++;
      if (redir_q.size() != 0 || chk_q.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations: got redirects=%0d reads=%0d left, expected 0",
                  redir_q.size(), chk_q.size());
      end
      summary();
      $finish;
   end

endmodule
